// File: rtl/multicycle_datapath_if.sv
// Instruction and data memory req/ack buses of the multi-cycle datapath.
// The master side is the datapath; the slave side is the memory system.
interface multicycle_datapath_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [2:0]      dmem_func3;
    logic            dmem_ack;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_func3,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_func3,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I datapath: FETCH/DECODE/EXEC/MEM/WB sequencer with
// req/ack instruction and data memory ports and branch PC redirect.
module multicycle_datapath #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_datapath_if.master bus,
    output logic [31:0]           instr,
    input  logic                  ALUSrc,
    input  logic                  MemtoReg,
    input  logic                  RegWrite,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  Branch,
    input  logic [4:0]            ALUControl,
    output logic [XLEN-1:0]       PC,
    output logic                  retire
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [4:0] ALU_PASS = 5'd10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t          state;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] mdr;
    logic [XLEN-1:0] rf [32];
    logic            imem_req;
    logic            dmem_req;
    logic            dmem_we;

    logic [4:0]        rs1_idx;
    logic [4:0]        rs2_idx;
    logic [4:0]        rd_idx;
    logic [2:0]        func3;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   opb;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res;
    logic              taken;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   pc_target;
    logic [XLEN-1:0]   wb_data;

    assign rs1_idx = ir[19:15];
    assign rs2_idx = ir[24:20];
    assign rd_idx  = ir[11:7];
    assign func3   = ir[14:12];

    assign rs1_val = (rs1_idx == 5'd0) ? '0 : rf[rs1_idx];
    assign rs2_val = (rs2_idx == 5'd0) ? '0 : rf[rs2_idx];

    // Immediate format follows the opcode; I-type is the fallback.
    always_comb begin
        imm32 = '0;
        case (ir[6:0])
            7'b0100011:
                imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011:
                imm32 = {{19{ir[31]}}, ir[31], ir[7],
                         ir[30:25], ir[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {ir[31:12], 12'b0};
            7'b1101111:
                imm32 = {{11{ir[31]}}, ir[31], ir[19:12],
                         ir[20], ir[30:21], 1'b0};
            default:
                imm32 = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    assign imm_ext = XLEN'(imm32);

    assign opb   = ALUSrc ? imm : b;
    assign shamt = opb[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (ALUControl)
            ALU_ADD:  alu_res = a + opb;
            ALU_SUB:  alu_res = a - opb;
            ALU_AND:  alu_res = a & opb;
            ALU_OR:   alu_res = a | opb;
            ALU_XOR:  alu_res = a ^ opb;
            ALU_SLL:  alu_res = a << shamt;
            ALU_SRL:  alu_res = a >> shamt;
            ALU_SRA:  alu_res = $signed(a) >>> shamt;
            ALU_SLT:  alu_res = XLEN'($signed(a) < $signed(opb));
            ALU_SLTU: alu_res = XLEN'(a < opb);
            ALU_PASS: alu_res = opb;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (func3)
            3'b000:  taken = (a == b);
            3'b001:  taken = (a != b);
            3'b100:  taken = ($signed(a) < $signed(b));
            3'b101:  taken = ($signed(a) >= $signed(b));
            3'b110:  taken = (a < b);
            3'b111:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

    assign pc_plus4  = pc + XLEN'(4);
    assign pc_target = pc + imm;
    assign wb_data   = MemtoReg ? mdr : alu_out;

    // Retire depends on the live data ack, so it cannot be registered.
    assign retire = (state == S_EXEC && Branch)
                 || (state == S_MEM && dmem_req && bus.dmem_ack && dmem_we)
                 || (state == S_WB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            imm      <= '0;
            alu_out  <= '0;
            mdr      <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            case (state)
                S_FETCH: begin
                    imem_req <= 1'b1;
                    if (imem_req && bus.imem_ack) begin
                        ir       <= bus.imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a     <= rs1_val;
                    b     <= rs2_val;
                    imm   <= imm_ext;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    if (Branch) begin
                        pc       <= taken ? pc_target : pc_plus4;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end else if (MemRead || MemWrite) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= MemWrite;
                        state    <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_req && bus.dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (dmem_we) begin
                            pc       <= pc_plus4;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            mdr   <= bus.dmem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (RegWrite && rd_idx != 5'd0) begin
                        rf[rd_idx] <= wb_data;
                    end
                    pc       <= pc_plus4;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.imem_addr  = pc;
    assign bus.dmem_req   = dmem_req;
    assign bus.dmem_we    = dmem_we;
    assign bus.dmem_addr  = alu_out;
    assign bus.dmem_wdata = b;
    assign bus.dmem_func3 = func3;

    assign instr = ir;
    assign PC    = pc;
endmodule
